// File: rtl/issue_select_rr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// issue_select_rr_ctrl_pkg
// Shared definitions for the round-robin issue select block: default queue
// geometry, the index widths derived from it, and the stall-lock state record.
// -----------------------------------------------------------------------------
package issue_select_rr_ctrl_pkg;

    localparam int unsigned ISSUE_ENTRIES   = 32;
    localparam int unsigned ISSUE_NUM_PARTS = 4;

    localparam int unsigned ISSUE_IDX_W     = $clog2(ISSUE_ENTRIES);
    localparam int unsigned ISSUE_PTR_W     = $clog2(ISSUE_NUM_PARTS);
    localparam int unsigned ISSUE_PART_SIZE = ISSUE_ENTRIES / ISSUE_NUM_PARTS;
    localparam int unsigned ISSUE_OFF_W     = $clog2(ISSUE_PART_SIZE);

    // Grant held across a functional-unit stall. The index field is sized for
    // the default queue depth; deeper queues need this width raised.
    typedef struct packed {
        logic                   vld;
        logic [ISSUE_IDX_W-1:0] idx;
    } issue_lock_t;

endpackage

// File: rtl/issue_select_rr_ctrl_part_picker.sv
// -----------------------------------------------------------------------------
// issue_part_picker
// Fixed-priority first-one finder for one round-robin partition.
//   req_i  : request bits of the partition
//   any_o  : at least one request present
//   idx_o  : offset of the lowest-index request (0 when none)
// -----------------------------------------------------------------------------
module issue_part_picker
    import issue_select_rr_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = ISSUE_PART_SIZE
) (
    input  logic [WIDTH-1:0]         req_i,
    output logic                     any_o,
    output logic [$clog2(WIDTH)-1:0] idx_o
);

    localparam int unsigned OFF_W = $clog2(WIDTH);

    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        // Scan from the top down so the lowest set bit is the last writer.
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (req_i[i-1]) begin
                idx_o = OFF_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/issue_select_rr_ctrl.sv
// -----------------------------------------------------------------------------
// issue_select_rr_ctrl
// Round-robin issue select over NUM_PARTS equal partitions of the request
// vector, with a grant lock that holds a stalled grant until it is accepted.
//
// Ports
//   clk           : clock, all state on rising edge
//   reset         : synchronous reset, active low
//   flush_i       : pipeline flush; suppresses the grant and drops the lock
//   ready_i       : per-entry issue requests
//   fu_ready_i    : functional unit accepts the grant this cycle
//   grant_o       : one-hot grant (zero when no grant)
//   grant_valid_o : grant_o is non-zero
//   grant_idx_o   : binary index of the grant (zero when no grant)
//   ptr_o         : current highest-priority partition
//   locked_o      : a stalled grant is being held
//
// Build option
//   ISSUE_RR_FREE_RUN_EN : priority pointer advances every cycle instead of
//                          only after an accepted grant.
// -----------------------------------------------------------------------------
module issue_select_rr_ctrl
    import issue_select_rr_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES   = ISSUE_ENTRIES,
    parameter int unsigned NUM_PARTS = ISSUE_NUM_PARTS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic [ENTRIES-1:0]           ready_i,
    input  logic                         fu_ready_i,
    output logic [ENTRIES-1:0]           grant_o,
    output logic                         grant_valid_o,
    output logic [$clog2(ENTRIES)-1:0]   grant_idx_o,
    output logic [$clog2(NUM_PARTS)-1:0] ptr_o,
    output logic                         locked_o
);

    localparam int unsigned IDX_W     = $clog2(ENTRIES);
    localparam int unsigned PTR_W     = $clog2(NUM_PARTS);
    localparam int unsigned PART_SIZE = ENTRIES / NUM_PARTS;
    localparam int unsigned OFF_W     = $clog2(PART_SIZE);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    issue_lock_t      lock_q, lock_d;

    logic [NUM_PARTS-1:0] part_any;
    logic [OFF_W-1:0]     part_off [NUM_PARTS];

    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] rr_part;
    logic             rr_valid;
    logic [IDX_W-1:0] rr_idx;

    logic [IDX_W-1:0] lock_idx;
    logic             lock_hit;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic             active;
    logic             fire;

    for (genvar p = 0; p < NUM_PARTS; p++) begin : g_part
        issue_part_picker #(
            .WIDTH (PART_SIZE)
        ) u_picker (
            .req_i (ready_i[p*PART_SIZE +: PART_SIZE]),
            .any_o (part_any[p]),
            .idx_o (part_off[p])
        );
    end

    // First partition with a request, searching upward from the pointer.
    // PTR_W-bit addition wraps modulo NUM_PARTS.
    always_comb begin
        rr_valid = 1'b0;
        rr_part  = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_PARTS; k++) begin
            cand = ptr_q + PTR_W'(k);
            if (!rr_valid && part_any[cand]) begin
                rr_valid = 1'b1;
                rr_part  = cand;
            end
        end
    end

    // Partitions are power-of-two sized, so the entry index is a concatenation.
    assign rr_idx = {rr_part, part_off[rr_part]};

    assign lock_idx  = IDX_W'(lock_q.idx);
    assign lock_hit  = lock_q.vld && ready_i[lock_idx];
    assign sel_idx   = lock_hit ? lock_idx : rr_idx;
    assign sel_valid = lock_hit || rr_valid;

    assign active        = reset && !flush_i;
    assign grant_valid_o = active && sel_valid;
    assign grant_idx_o   = grant_valid_o ? sel_idx : '0;
    assign locked_o      = active && lock_hit;
    assign ptr_o         = reset ? ptr_q : '0;
    assign fire          = grant_valid_o && fu_ready_i;

    always_comb begin
        grant_o = '0;
        if (grant_valid_o) begin
            grant_o[sel_idx] = 1'b1;
        end
    end

    always_comb begin
`ifdef ISSUE_RR_FREE_RUN_EN
        ptr_d = ptr_q + PTR_W'(1);
`else
        ptr_d = fire ? (sel_idx[IDX_W-1 -: PTR_W] + PTR_W'(1)) : ptr_q;
`endif
        // A stalled grant (valid, not accepted, no flush) is captured; every
        // other outcome -- accept, flush, or no grant after the request
        // dropped -- leaves the lock clear. While held, the grant equals the
        // lock index, so recapturing it keeps the lock stable.
        lock_d.vld = grant_valid_o && !fu_ready_i;
        lock_d.idx = lock_d.vld ? ISSUE_IDX_W'(sel_idx) : lock_q.idx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q      <= '0;
            lock_q.vld <= 1'b0;
            lock_q.idx <= '0;
        end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
        end
    end

endmodule

// File: tb/tb_issue_select_rr_ctrl.sv
module tb_issue_select_rr_ctrl;

    localparam int ENT   = 32;
    localparam int PARTS = 4;
    localparam int PSZ   = ENT / PARTS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush_i = 1'b0;
    logic [ENT-1:0] ready_i = '0;
    logic          fu_ready_i = 1'b0;
    logic [ENT-1:0] grant_o;
    logic          grant_valid_o;
    logic [4:0]    grant_idx_o;
    logic [1:0]    ptr_o;
    logic          locked_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    int m_ptr      = 0;
    int m_lock_vld = 0;
    int m_lock_idx = 0;

    issue_select_rr_ctrl #(
        .ENTRIES   (ENT),
        .NUM_PARTS (PARTS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush_i       (flush_i),
        .ready_i       (ready_i),
        .fu_ready_i    (fu_ready_i),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .grant_idx_o   (grant_idx_o),
        .ptr_o         (ptr_o),
        .locked_o      (locked_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, compare against the reference, then advance it.
    task automatic step(input logic r, input logic f, input logic [31:0] rdy,
                        input logic fu, input string tag);
        logic [31:0] eg;
        int          eidx;
        int          ev;
        int          el;
        int          eptr;
        @(negedge clk);
        reset      = r;
        flush_i    = f;
        ready_i    = rdy;
        fu_ready_i = fu;
        #1;
        ev = 0; eidx = 0; el = 0;
        if (r && !f) begin
            if (m_lock_vld != 0 && rdy[m_lock_idx]) begin
                ev = 1; eidx = m_lock_idx; el = 1;
            end else begin
                for (int k = 0; k < PARTS; k++) begin
                    int part;
                    part = (m_ptr + k) % PARTS;
                    for (int e = part * PSZ; e < part * PSZ + PSZ; e++) begin
                        if (ev == 0 && rdy[e]) begin
                            ev = 1; eidx = e;
                        end
                    end
                end
            end
        end
        eg   = (ev != 0) ? (32'h1 << eidx) : 32'h0;
        eptr = r ? m_ptr : 0;
        chk({tag, "/grant"},  grant_o, eg);
        chk({tag, "/valid"},  32'(grant_valid_o), 32'(ev));
        chk({tag, "/idx"},    32'(grant_idx_o), 32'(eidx));
        chk({tag, "/ptr"},    32'(ptr_o), 32'(eptr));
        chk({tag, "/locked"}, 32'(locked_o), 32'(el));
        // Next state by the block's rules
        if (!r) begin
            m_ptr = 0; m_lock_vld = 0;
        end else begin
`ifdef ISSUE_RR_FREE_RUN_EN
            m_ptr = (m_ptr + 1) % PARTS;
`else
            if (ev != 0 && fu) m_ptr = (eidx / PSZ + 1) % PARTS;
`endif
            if (ev != 0 && !fu) begin
                m_lock_vld = 1; m_lock_idx = eidx;
            end else begin
                m_lock_vld = 0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rnd_ready;
        logic        r, f, fu;

        // Reset state: outputs forced low even with requests present
        step(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, "rst0");
        step(1'b0, 1'b1, 32'h0000_0101, 1'b0, "rst1");
        chk("rst_valid", 32'(grant_valid_o), 32'd0);

`ifndef ISSUE_RR_FREE_RUN_EN
        // Two requests in different partitions alternate
        step(1'b1, 1'b0, 32'h0000_0101, 1'b1, "r29a");
        chk("r29a_idx", 32'(grant_idx_o), 32'd0);
        step(1'b1, 1'b0, 32'h0000_0101, 1'b1, "r29b");
        chk("r29b_idx", 32'(grant_idx_o), 32'd8);
        chk("r29b_ptr", 32'(ptr_o), 32'd1);
        step(1'b1, 1'b0, 32'h0000_0101, 1'b0, "r29c");
        chk("r29c_ptr", 32'(ptr_o), 32'd2);

        // All requesting: pointer sweeps every partition and wraps
        step(1'b0, 1'b0, 32'h0, 1'b0, "r30rst");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, "r30");
            chk("r30_idx", 32'(grant_idx_o), 32'((i % 4) * 8));
            chk("r30_ptr", 32'(ptr_o), 32'(i % 4));
        end

        // Stall holds index 4 against a higher-priority newcomer
        step(1'b0, 1'b0, 32'h0, 1'b0, "r31rst");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h10, 1'b0, "r31s");
            chk("r31s_idx", 32'(grant_idx_o), 32'd4);
            chk("r31s_lock", 32'(locked_o), 32'(i > 0));
        end
        step(1'b1, 1'b0, 32'h12, 1'b0, "r31h");
        chk("r31h_idx", 32'(grant_idx_o), 32'd4);
        chk("r31h_lock", 32'(locked_o), 32'd1);
        chk("r31h_ptr", 32'(ptr_o), 32'd0);
        step(1'b1, 1'b0, 32'h12, 1'b1, "r31f");
        chk("r31f_idx", 32'(grant_idx_o), 32'd4);
        step(1'b1, 1'b0, 32'h12, 1'b0, "r31n");
        chk("r31n_lock", 32'(locked_o), 32'd0);
        chk("r31n_ptr", 32'(ptr_o), 32'd1);
        chk("r31n_idx", 32'(grant_idx_o), 32'd1);

        // Locked request drops: same-cycle recompute
        step(1'b0, 1'b0, 32'h0, 1'b0, "r32rst");
        step(1'b1, 1'b0, 32'h10, 1'b0, "r32a");
        step(1'b1, 1'b0, 32'h10, 1'b0, "r32b");
        chk("r32b_lock", 32'(locked_o), 32'd1);
        step(1'b1, 1'b0, 32'h02, 1'b0, "r32c");
        chk("r32c_idx", 32'(grant_idx_o), 32'd1);
        chk("r32c_lock", 32'(locked_o), 32'd0);

        // Flush drops the lock
        step(1'b0, 1'b0, 32'h0, 1'b0, "r33rst");
        step(1'b1, 1'b0, 32'h10, 1'b0, "r33a");
        step(1'b1, 1'b0, 32'h10, 1'b0, "r33b");
        step(1'b1, 1'b1, 32'h12, 1'b0, "r33f");
        chk("r33f_valid", 32'(grant_valid_o), 32'd0);
        step(1'b1, 1'b0, 32'h12, 1'b1, "r33n");
        chk("r33n_idx", 32'(grant_idx_o), 32'd1);

        // Reset mid-stall discards the lock
        step(1'b0, 1'b0, 32'h0, 1'b0, "r24rst");
        step(1'b1, 1'b0, 32'h10, 1'b0, "r24a");
        step(1'b1, 1'b0, 32'h10, 1'b0, "r24b");
        step(1'b0, 1'b0, 32'h12, 1'b0, "r24r");
        step(1'b1, 1'b0, 32'h12, 1'b0, "r24n");
        chk("r24n_idx", 32'(grant_idx_o), 32'd1);
        chk("r24n_lock", 32'(locked_o), 32'd0);
`else
        // Free-running pointer
        step(1'b0, 1'b0, 32'h0, 1'b0, "r34rst");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, "r34");
            chk("r34_ptr", 32'(ptr_o), 32'(i % 4));
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, "r34m");
        step(1'b0, 1'b0, 32'h0, 1'b0, "r34r");
        step(1'b1, 1'b0, 32'h0, 1'b0, "r34p");
        chk("r34p_ptr", 32'(ptr_o), 32'd0);
`endif

        // Randomized traffic against the reference
        step(1'b0, 1'b0, 32'h0, 1'b0, "rndrst");
        rnd_ready = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0: rnd_ready = 32'h0;
                    1: rnd_ready = 32'h1 << $urandom_range(0, 31);
                    2: rnd_ready = $urandom & $urandom & $urandom;
                    default: rnd_ready = $urandom;
                endcase
            end
            r  = ($urandom_range(0, 39) != 0);
            f  = ($urandom_range(0, 11) == 0);
            fu = ($urandom_range(0, 9) < 6);
            step(r, f, rnd_ready, fu, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/issue_select_rr_ctrl.md
ISSUE_SELECT_RR_CTRL -- requirements
Module: issue_select_rr_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, meaning the number of issue-queue request bits (power of 2).
REQ-002 SHALL have parameter NUM_PARTS, default 4, meaning the number of equal round-robin partitions (power of 2, divides ENTRIES).
REQ-003 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  meaning synchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port flush_i  in  1  meaning pipeline flush, which clears the grant lock.
REQ-006 SHALL have port ready_i  in  ENTRIES  meaning the per-entry issue request vector.
REQ-007 SHALL have port fu_ready_i  in  1  meaning the functional unit accepts the grant this cycle.
REQ-008 SHALL have port grant_o  out  ENTRIES  meaning the one-hot grant, all-zero when there is no grant.
REQ-009 SHALL have port grant_valid_o  out  1  meaning grant_o is non-zero.
REQ-010 SHALL have port grant_idx_o  out  $clog2(ENTRIES)  meaning the binary index of the grant, 0 when there is no grant.
REQ-011 SHALL have port ptr_o  out  $clog2(NUM_PARTS)  meaning the current highest-priority partition.
REQ-012 SHALL have port locked_o  out  1  meaning a stalled grant is being held.

Function
REQ-013 SHALL produce the grant combinationally from ready_i and registered state, with zero-cycle latency.
REQ-014 SHALL search partitions in order ptr, ptr+1, ... modulo NUM_PARTS, and select the first partition with any request.
REQ-015 SHALL select the lowest-index requesting entry within the selected partition.
REQ-016 SHALL define fire as grant_valid_o && fu_ready_i && !flush_i.
REQ-017 SHALL, on fire, set ptr to (granted partition + 1) mod NUM_PARTS; otherwise ptr SHALL hold.
REQ-018 SHALL, when grant_valid_o && !fu_ready_i && !flush_i, set lock_vld and capture lock_idx = grant_idx_o.
REQ-019 SHALL, while lock_vld && ready_i[lock_idx], output grant = lock_idx regardless of ptr or new requests, and assert locked_o.
REQ-020 SHALL clear lock_vld on fire, on flush_i, or when ready_i[lock_idx]==0; in the request-dropped case the grant SHALL be recomputed by REQ-014/015 in the same cycle.
REQ-021 SHALL force grant_valid_o=0 and grant_o=0 during flush_i, with ptr unchanged.
REQ-022 SHALL, when ready_i==0, drive grant_valid_o=0, grant_o=0, grant_idx_o=0.

Reset
REQ-023 SHALL, while reset==0, set ptr=0 and lock_vld=0 at the clock edge, and force grant_o=0, grant_valid_o=0, grant_idx_o=0, locked_o=0, ptr_o=0.
REQ-024 SHALL give reset priority over flush_i and fire, and SHALL discard an in-progress lock when reset is asserted mid-stall.

Configuration
REQ-025 SHALL, with ISSUE_RR_FREE_RUN_EN defined, advance ptr by 1 mod NUM_PARTS every non-reset cycle, independent of fire (the lock still applies).
REQ-026 SHALL, without ISSUE_RR_FREE_RUN_EN, update ptr only per REQ-017.

Structure
REQ-027 SHALL place ENTRIES/NUM_PARTS defaults, the derived index widths and the lock-state struct typedef in the shared issue package.
REQ-028 SHALL use one sub-module, issue_part_picker (fixed-priority first-one find plus any-request flag for one partition), instantiated NUM_PARTS times.

Verification (ENTRIES=32, NUM_PARTS=4)
REQ-029 SHALL cover: ready_i=0x0000_0101, fu_ready_i=1 from reset release -> grant_idx 0, ptr 1; next cycle grant_idx 8, ptr 2.
REQ-030 SHALL cover: ready_i=0xFFFF_FFFF, fu_ready_i=1 for 5 cycles -> grant_idx 0, 8, 16, 24, 0 and ptr 1, 2, 3, 0, 1.
REQ-031 SHALL cover: ready_i=0x10, fu_ready_i=0 for 3 cycles, then ready_i=0x12 -> grant_idx stays 4 with locked_o=1 and ptr=0; then fu_ready_i=1 -> fire on 4, locked_o=0.
REQ-032 SHALL cover: locked on index 4, then ready_i changes to 0x02 -> same-cycle grant_idx 1, locked_o=0.
REQ-033 SHALL cover: locked on index 4, then flush_i=1 for one cycle -> grant_valid_o=0 that cycle; next cycle with ready_i=0x12 and ptr=0 -> grant_idx 1.
REQ-034 SHALL cover: ISSUE_RR_FREE_RUN_EN defined, ready_i=0, 5 cycles after reset -> ptr_o 0, 1, 2, 3, 0; reset=0 mid-sequence -> ptr_o=0 at the next edge.
